wb_result_arbiter: RTL

Writeback collector for the execute stage. It receives results tagged with a transaction ID from the functional units fed by the operand-issue stage (fixed-latency unit, load, store, FPU). It buffers each unit's results in a small per-source FIFO and arbitrates them round-robin onto the scoreboard's writeback ports. It is the return path of the issue interface: trans_id goes out with the operands at issue and comes back here with the result.

---
 rtl/wb_result_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wb_result_arbiter.sv
// Writeback collector: per-source result FIFOs drained round-robin onto the scoreboard writeback ports.
// Latency: a result accepted in cycle c can be granted in c+1 and is shown on wb_*_o in c+2.
// Backpressure: src_ready_o drops when a source FIFO is full; the scoreboard side never stalls.
module wb_result_arbiter #(
    parameter int unsigned NR_SRC        = 4,
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter int unsigned NR_WB_PORTS   = 2,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [NR_SRC-1:0]        src_valid_i,
    output logic [NR_SRC-1:0]        src_ready_o,
    input  logic [TRANS_ID_BITS-1:0] src_trans_id_i [NR_SRC-1:0],
    input  logic [63:0]              src_result_i   [NR_SRC-1:0],
    input  logic [NR_SRC-1:0]        src_ex_valid_i,
    input  logic [63:0]              src_ex_cause_i [NR_SRC-1:0],
    output logic [NR_WB_PORTS-1:0]   wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o  [NR_WB_PORTS-1:0],
    output logic [63:0]              wb_result_o    [NR_WB_PORTS-1:0],
    output logic [NR_WB_PORTS-1:0]   wb_ex_valid_o,
    output logic [63:0]              wb_ex_cause_o  [NR_WB_PORTS-1:0]
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned RR_W  = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
    localparam int unsigned RR_W1 = RR_W + 1;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [63:0]              result;
        logic                     ex_valid;
        logic [63:0]              ex_cause;
    } entry_t;

    entry_t           mem_q    [NR_SRC-1:0][FIFO_DEPTH-1:0];
    logic [PTR_W-1:0] rd_ptr_q [NR_SRC-1:0];
    logic [PTR_W-1:0] wr_ptr_q [NR_SRC-1:0];
    logic [CNT_W-1:0] cnt_q    [NR_SRC-1:0];
    logic [RR_W-1:0]  rr_q, rr_d;

    logic [NR_SRC-1:0] push, pop, nonempty, taken;
    entry_t            src_ent [NR_SRC-1:0];
    entry_t            head    [NR_SRC-1:0];

    logic [NR_WB_PORTS-1:0] port_vld;
    logic [RR_W-1:0]        port_src [NR_WB_PORTS-1:0];
    logic [RR_W:0]          arb_sum;
    logic [RR_W-1:0]        arb_idx;
    logic                   prev_ok;

    logic [NR_WB_PORTS-1:0]   wb_valid_q, wb_ex_valid_q;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_q [NR_WB_PORTS-1:0];
    logic [63:0]              wb_result_q   [NR_WB_PORTS-1:0];
    logic [63:0]              wb_ex_cause_q [NR_WB_PORTS-1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready from registered occupancy only; push qualification and head/tail entries per source.
    always_comb begin
        for (int i = 0; i < NR_SRC; i++) begin
            src_ready_o[i] = (cnt_q[i] < CNT_W'(FIFO_DEPTH));
            nonempty[i]    = (cnt_q[i] != '0);
            src_ent[i]     = '{trans_id: src_trans_id_i[i], result: src_result_i[i],
                               ex_valid: src_ex_valid_i[i], ex_cause: src_ex_cause_i[i]};
            head[i]        = mem_q[i][rd_ptr_q[i]];
        end
        push = src_valid_i & src_ready_o & {NR_SRC{~flush_i}};
    end

    // Round-robin scan from rr_q: each port takes the next untaken non-empty source, ports fill in order.
    always_comb begin
        taken    = '0;
        port_vld = '0;
        arb_sum  = '0;
        arb_idx  = '0;
        prev_ok  = 1'b1;
        rr_d     = rr_q;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            port_src[p] = '0;
        end
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            for (int k = 0; k < NR_SRC; k++) begin
                arb_sum = RR_W1'(rr_q) + RR_W1'(k);
                if (arb_sum >= RR_W1'(NR_SRC)) begin
                    arb_sum = arb_sum - RR_W1'(NR_SRC);
                end
                arb_idx = arb_sum[RR_W-1:0];
                if (prev_ok && !port_vld[p] && nonempty[arb_idx] && !taken[arb_idx]) begin
                    port_vld[p]     = 1'b1;
                    port_src[p]     = arb_idx;
                    taken[arb_idx]  = 1'b1;
                end
            end
            prev_ok = port_vld[p];
            if (port_vld[p]) begin
                arb_sum = RR_W1'(port_src[p]) + RR_W1'(1);
                if (arb_sum >= RR_W1'(NR_SRC)) begin
                    arb_sum = '0;
                end
                rr_d = arb_sum[RR_W-1:0];
            end
        end
        pop = taken & {NR_SRC{~flush_i}};
    end

    // FIFO pointers, occupancy and round-robin pointer; flush wipes them all.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_SRC; i++) begin
                cnt_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
            rr_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < NR_SRC; i++) begin
                cnt_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
            rr_q <= '0;
        end else begin
            for (int i = 0; i < NR_SRC; i++) begin
                if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
                if (pop[i])  rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                else if (pop[i] && !push[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
            rr_q <= rr_d;
        end
    end

    // FIFO storage writes the tail; no reset needed since occupancy guards every read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_SRC; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= src_ent[i];
        end
    end

    // Writeback registers load the granted heads; valid is single-cycle and cleared by flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_q    <= '0;
            wb_ex_valid_q <= '0;
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                wb_trans_id_q[p] <= '0;
                wb_result_q[p]   <= '0;
                wb_ex_cause_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                wb_valid_q[p] <= port_vld[p] & ~flush_i;
                if (port_vld[p] && !flush_i) begin
                    wb_trans_id_q[p] <= head[port_src[p]].trans_id;
                    wb_result_q[p]   <= head[port_src[p]].result;
                    wb_ex_valid_q[p] <= head[port_src[p]].ex_valid;
                    wb_ex_cause_q[p] <= head[port_src[p]].ex_cause;
                end
            end
        end
    end

    // Drive outputs straight from the writeback registers.
    always_comb begin
        wb_valid_o    = wb_valid_q;
        wb_ex_valid_o = wb_ex_valid_q;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            wb_trans_id_o[p] = wb_trans_id_q[p];
            wb_result_o[p]   = wb_result_q[p];
            wb_ex_cause_o[p] = wb_ex_cause_q[p];
        end
    end

endmodule
